// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Purpose  : Seven-segment font, all-off patterns and scan state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  // Active-low segments, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ssd_scan_controller_hex_to_ssd.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_ssd
// Purpose  : Combinational hex nibble to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_controller
// Purpose  : 4-digit common-anode display scanner with frame-aligned updates.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int DIV_MAX = 50000,
  parameter int DEAD    = 4,
  parameter int PRE_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_blank,
  output logic        upd_ready,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_MAX - 1);

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       shadow_data_q, shadow_data_d;
  logic [3:0]        shadow_blank_q, shadow_blank_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        cathode_q, cathode_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              boundary;
  logic              accept;
  logic              in_dead;
  logic [3:0]        nibble;
  logic [6:0]        seg;

  assign tick      = (state_q == SCAN) && (pre_q == PRE_LAST);
  assign boundary  = tick && (idx_q == 2'd3);
  assign upd_ready = (state_q == LOAD) || boundary;
  assign accept    = upd_valid && upd_ready;

  always_comb begin
    state_d        = state_q;
    pre_d          = pre_q;
    idx_d          = idx_q;
    shadow_data_d  = shadow_data_q;
    shadow_blank_d = shadow_blank_q;

    if (accept) begin
      shadow_data_d  = upd_data;
      shadow_blank_d = upd_blank;
    end

    if (state_q == LOAD) begin
      if (upd_valid) begin
        state_d = SCAN;
        pre_d   = '0;
        idx_d   = 2'd0;
      end
    end else if (tick) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Outputs are derived from next-state values so they register in step with digit_idx.
  generate
    if (DEAD > 0) begin : g_dead
      localparam logic [PRE_W-1:0] DEAD_END = PRE_W'(DEAD);
      assign in_dead = (pre_d < DEAD_END);
    end else begin : g_no_dead
      assign in_dead = 1'b0;
    end
  endgenerate

  assign nibble = 4'(shadow_data_d >> {idx_d, 2'b00});

  hex_to_ssd u_font (
    .hex (nibble),
    .seg (seg)
  );

  always_comb begin
    anode_d      = AN_OFF;
    cathode_d    = SEG_OFF;
    frame_done_d = 1'b0;
    if (state_d == SCAN) begin
      frame_done_d = (pre_d == '0) && (idx_d == 2'd0);
      if (!in_dead && !shadow_blank_d[idx_d]) begin
        anode_d   = ~(4'b0001 << idx_d);
        cathode_d = seg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= LOAD;
      pre_q          <= '0;
      idx_q          <= 2'd0;
      shadow_data_q  <= 16'h0000;
      shadow_blank_q <= 4'h0;
      anode_q        <= AN_OFF;
      cathode_q      <= SEG_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      idx_q          <= idx_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blank_q <= shadow_blank_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_controller
// Purpose  : Directed table-driven bench for ssd_scan_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

  logic        clk;
  logic        reset;
  logic        upd_valid;
  logic        upd_valid0;
  logic [15:0] upd_data;
  logic [3:0]  upd_blank;
  logic        upd_ready, upd_ready0;
  logic [3:0]  anode, anode0;
  logic [6:0]  cathode, cathode0;
  logic [1:0]  digit_idx, digit_idx0;
  logic        frame_done, frame_done0;

  int n_cmp = 0;
  int n_err = 0;

  ssd_scan_controller #(.DIV_MAX(4), .DEAD(1), .PRE_W(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_blank  (upd_blank),
    .upd_ready  (upd_ready),
    .anode      (anode),
    .cathode    (cathode),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  ssd_scan_controller #(.DIV_MAX(3), .DEAD(0), .PRE_W(2)) u_dut_nodead (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid0),
    .upd_data   (upd_data),
    .upd_blank  (upd_blank),
    .upd_ready  (upd_ready0),
    .anode      (anode0),
    .cathode    (cathode0),
    .digit_idx  (digit_idx0),
    .frame_done (frame_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [3:0]  an;
    logic [6:0]  cat;
    logic [1:0]  idx;
    logic        fd;
    logic        rdy;
  } vec_t;

  localparam int NVEC = 33;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] b);
    int cnt;
    cnt = 0;
    upd_valid = 1'b1;
    upd_data  = d;
    upd_blank = b;
    while (!upd_ready && cnt < 100) begin
      step();
      cnt++;
    end
    check("load_wait_timeout", 16'(cnt >= 100), 16'd0);
    step();
    upd_valid = 1'b0;
    upd_data  = 16'h5555;
  endtask

  initial begin
    logic [3:0] an_lit  [4];
    logic [6:0] cat1234 [4];
    int pos, slot, pre, cnt, bad;
    logic lit;

    an_lit[0] = 4'hE; an_lit[1] = 4'hD; an_lit[2] = 4'hB; an_lit[3] = 4'h7;
    cat1234[0] = 7'h19; cat1234[1] = 7'h30; cat1234[2] = 7'h24; cat1234[3] = 7'h79;

    // Vector k drives inputs for the edge that leaves the DUT at frame position k mod 16.
    for (int k = 0; k < NVEC; k++) begin
      pos  = k % 16;
      slot = pos / 4;
      pre  = pos % 4;
      tbl[k].valid = (k == 0);
      tbl[k].data  = (k == 0) ? 16'h1234 : 16'h5555;
      tbl[k].an    = (pre == 0) ? 4'hF  : an_lit[slot];
      tbl[k].cat   = (pre == 0) ? 7'h7F : cat1234[slot];
      tbl[k].idx   = 2'(slot);
      tbl[k].fd    = (pos == 0);
      tbl[k].rdy   = (pos == 15);
    end

    reset      = 1'b1;
    upd_valid  = 1'b0;
    upd_valid0 = 1'b0;
    upd_data   = 16'h0000;
    upd_blank  = 4'h0;
    #2;
    check("rst_anode",   16'(anode),      16'hF);
    check("rst_cathode", 16'(cathode),    16'h7F);
    check("rst_ready",   16'(upd_ready),  16'd1);
    check("rst_idx",     16'(digit_idx),  16'd0);
    check("rst_fd",      16'(frame_done), 16'd0);

    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    check("load_idle_anode", 16'(anode),     16'hF);
    check("load_idle_ready", 16'(upd_ready), 16'd1);

    // Initial load of 1234 followed by two frames with no update offered.
    for (int k = 0; k < NVEC; k++) begin
      upd_valid = tbl[k].valid;
      upd_data  = tbl[k].data;
      upd_blank = 4'h0;
      step();
      check($sformatf("tbl%0d_anode", k),   16'(anode),      16'(tbl[k].an));
      check($sformatf("tbl%0d_cathode", k), 16'(cathode),    16'(tbl[k].cat));
      check($sformatf("tbl%0d_idx", k),     16'(digit_idx),  16'(tbl[k].idx));
      check($sformatf("tbl%0d_fd", k),      16'(frame_done), 16'(tbl[k].fd));
      check($sformatf("tbl%0d_ready", k),   16'(upd_ready),  16'(tbl[k].rdy));
    end
    upd_valid = 1'b0;

    // Held update offered from digit 1, accepted only at the digit-3 tick.
    repeat (4) step();
    upd_valid = 1'b1;
    upd_data  = 16'hABCD;
    cnt = 0;
    while (!upd_ready && cnt < 40) begin
      step();
      cnt++;
    end
    check("held_wait_cycles", 16'(cnt), 16'd11);
    step();
    upd_valid = 1'b0;
    upd_data  = 16'h5555;
    check("held_fd",    16'(frame_done), 16'd1);
    check("held_idx",   16'(digit_idx),  16'd0);
    check("held_dead",  16'(anode),      16'hF);
    step();
    check("held_d0_an",  16'(anode),   16'hE);
    check("held_d0_cat", 16'(cathode), 16'h21);
    repeat (4) step();
    check("held_d1_an",  16'(anode),   16'hD);
    check("held_d1_cat", 16'(cathode), 16'h46);
    repeat (4) step();
    check("held_d2_an",  16'(anode),   16'hB);
    check("held_d2_cat", 16'(cathode), 16'h03);
    repeat (4) step();
    check("held_d3_an",  16'(anode),   16'h7);
    check("held_d3_cat", 16'(cathode), 16'h08);

    // Blank mask: digits 2 and 3 of 0042 stay dark.
    load(16'h0042, 4'b1100);
    for (int i = 1; i <= 16; i++) begin
      step();
      pos  = i % 16;
      slot = pos / 4;
      pre  = pos % 4;
      lit  = (pre != 0) && (slot < 2);
      check($sformatf("blank_p%0d_an", pos), 16'(anode),
            lit ? ((slot == 0) ? 16'hE : 16'hD) : 16'hF);
      check($sformatf("blank_p%0d_cat", pos), 16'(cathode),
            lit ? ((slot == 0) ? 16'h24 : 16'h19) : 16'h7F);
    end

    // Reset in the middle of digit 2, then idle in LOAD.
    load(16'h1234, 4'h0);
    repeat (9) step();
    check("pre_rst_an",  16'(anode),   16'hB);
    check("pre_rst_cat", 16'(cathode), 16'h24);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_anode",   16'(anode),      16'hF);
    check("midrst_cathode", 16'(cathode),    16'h7F);
    check("midrst_idx",     16'(digit_idx),  16'd0);
    check("midrst_ready",   16'(upd_ready),  16'd1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (anode !== 4'hF || cathode !== 7'h7F) bad++;
    end
    check("idle_dark_cycles", 16'(bad), 16'd0);
    check("idle_ready", 16'(upd_ready), 16'd1);
    load(16'h1234, 4'h0);
    check("reload_idx",  16'(digit_idx),  16'd0);
    check("reload_fd",   16'(frame_done), 16'd1);
    check("reload_dead", 16'(anode),      16'hF);
    step();
    check("reload_an",  16'(anode),   16'hE);
    check("reload_cat", 16'(cathode), 16'h19);

    // DEAD=0 instance: digits light from the very first slot cycle.
    upd_data   = 16'h1234;
    upd_blank  = 4'h0;
    upd_valid0 = 1'b1;
    step();
    upd_valid0 = 1'b0;
    check("nd_p0_an",  16'(anode0),      16'hE);
    check("nd_p0_cat", 16'(cathode0),    16'h19);
    check("nd_p0_fd",  16'(frame_done0), 16'd1);
    step();
    check("nd_p1_fd",  16'(frame_done0), 16'd0);
    step();
    step();
    check("nd_p3_idx", 16'(digit_idx0), 16'd1);
    check("nd_p3_an",  16'(anode0),     16'hD);
    check("nd_p3_cat", 16'(cathode0),   16'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
